// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic unit: FSM state encoding
// and the add/subtract mode selector values.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_add_sub_cell.sv
// One-bit combinational cell: full subtractor (mode=0) or full adder (mode=1).
// The sum/difference bit is identical in both modes; only the carry/borrow differs.
module full_add_sub_cell
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic out,
  output logic cout
);

  logic diff_s;

  assign diff_s = x ^ y;
  assign out    = diff_s ^ cin;

  // Carry-out for add, borrow-out for subtract
  always_comb begin
    cout = 1'b0;
    case (mode)
      MODE_SUB: cout = (~x & y) | (~diff_s & cin);
      MODE_ADD: cout = (x & y) | (cin & diff_s);
      default:  cout = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, through a
// single add/sub cell, with carry/borrow, signed-overflow and zero flags.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             mode_q, mode_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cb_q, cb_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             bit_s;
  logic             cout_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_shift_s;

  full_add_sub_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (c_q),
    .mode (mode_q),
    .out  (bit_s),
    .cout (cout_s)
  );

  assign res_shift_s = {bit_s, res_q[WIDTH-1:1]};

  // On the final bit, bit_s is the result MSB, so overflow is known this cycle
  always_comb begin
    ovf_s = 1'b0;
    case (mode_q)
      MODE_SUB: ovf_s = (a_msb_q != b_msb_q) && (bit_s != a_msb_q);
      MODE_ADD: ovf_s = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
      default:  ovf_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    mode_d  = mode_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cb_d    = cb_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          c_d     = 1'b0;
          cnt_d   = '0;
          cb_d    = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_shift_s;
        c_d   = cout_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cb_d    = cout_s;
          ovf_d   = ovf_s;
          zero_d  = (res_shift_s == {WIDTH{1'b0}});
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      mode_q  <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = res_q;
  assign carry_borrow = cb_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized self-checking bench for serial_add_sub at WIDTH=8 and WIDTH=3,
// checked against an arithmetic reference model.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       busy8, done8, cb8, ovf8, zero8;
  logic [7:0] res8;

  logic       start3 = 1'b0, mode3 = 1'b0;
  logic [2:0] a3 = 3'd0, b3 = 3'd0;
  logic       busy3, done3, cb3, ovf3, zero3;
  logic [2:0] res3;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_borrow(cb8),
    .overflow(ovf8), .zero(zero8)
  );

  serial_add_sub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(res3), .carry_borrow(cb3),
    .overflow(ovf3), .zero(zero3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain-integer reference: sum/difference, carry-out / borrow, signed overflow
  function automatic void model(input int w, input logic m, input longint av, input longint bv,
                                output longint r, output longint c, output longint o,
                                output longint z);
    longint full, sa, sb, sr, lim;
    lim  = longint'(1) << (w - 1);
    full = m ? (av + bv) : (av - bv);
    r    = full & ((longint'(1) << w) - 1);
    c    = m ? ((full >> w) & 1) : longint'(av < bv);
    sa   = (av >= lim) ? av - (lim << 1) : av;
    sb   = (bv >= lim) ? bv - (lim << 1) : bv;
    sr   = m ? (sa + sb) : (sa - sb);
    o    = longint'((sr < -lim) || (sr > lim - 1));
    z    = longint'(r == 0);
  endfunction

  // One WIDTH=8 operation; glitch_at>0 re-asserts start mid-RUN, hold_chk checks the post-done cycle
  task automatic op8(input logic m, input logic [7:0] av, input logic [7:0] bv,
                     input int glitch_at, input bit hold_chk);
    longint er, ec, eo, ez;
    int lat, bcnt;
    model(8, m, av, bv, er, ec, eo, ez);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < 20) begin
      if (glitch_at > 0 && lat == glitch_at) begin
        start8 = 1'b1; a8 = ~av; b8 = ~bv; mode8 = ~m;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
    start8 = 1'b0;
    check("latency8", lat, 8);
    check("busy_cycles8", bcnt, 8);
    check("done_busy8", busy8, 0);
    check("result8", res8, er);
    check("carry_borrow8", cb8, ec);
    check("overflow8", ovf8, eo);
    check("zero8", zero8, ez);
    if (hold_chk) begin
      @(posedge clk); #1;
      check("done_pulse8", done8, 0);
      check("idle_busy8", busy8, 0);
      check("result_held8", res8, er);
      check("carry_held8", cb8, ec);
    end
  endtask

  task automatic op3(input logic m, input logic [2:0] av, input logic [2:0] bv);
    longint er, ec, eo, ez;
    int lat;
    model(3, m, av, bv, er, ec, eo, ez);
    @(negedge clk);
    start3 = 1'b1; mode3 = m; a3 = av; b3 = bv;
    @(posedge clk); #1;
    start3 = 1'b0; a3 = 3'($urandom);
    lat = 0;
    while (!done3 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency3", lat, 3);
    check("result3", res3, er);
    check("carry_borrow3", cb3, ec);
    check("overflow3", ovf3, eo);
    check("zero3", zero3, ez);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_done"}, done8, 0);
    check({tag, "_result"}, res8, 0);
    check({tag, "_cb"}, cb8, 0);
    check({tag, "_ovf"}, ovf8, 0);
    check({tag, "_zero"}, zero8, 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    check("reset3_result", res3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    op8(1'b0, 8'd5,    8'd3,    0, 1'b1);
    op8(1'b0, 8'd3,    8'd5,    0, 1'b1);
    op8(1'b0, 8'h80,   8'h01,   0, 1'b1);
    op8(1'b1, 8'hFF,   8'h01,   0, 1'b1);
    op8(1'b1, 8'h7F,   8'h01,   0, 1'b1);

    // Start during RUN is ignored
    op8(1'b0, 8'h5A, 8'h33, 3, 1'b1);

    // Back-to-back: second start lands in the DONE cycle of the first
    op8(1'b1, 8'h12, 8'h34, 0, 1'b0);
    op8(1'b0, 8'h40, 8'hC0, 0, 1'b0);
    op8(1'b1, 8'h80, 8'h80, 0, 1'b1);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    op8(1'b0, 8'h01, 8'h02, 0, 1'b1);

    // Random WIDTH=8 operations
    for (int i = 0; i < 40; i++) begin
      op8(1'($urandom), 8'($urandom), 8'($urandom), 0, 1'($urandom));
    end

    // Exhaustive WIDTH=3
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          op3(1'(m), 3'(x), 3'(y));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
